// File: rtl/leaf_user_bridge.sv
// leaf_user_bridge: per-channel FIFO bridge between leaf_interface vld/ack ports and HLS kernel AXI-stream ports with kernel start/done sequencing; define LEAF_BRIDGE_CNT_EN for per-channel transfer counters on word_cnt
module leaf_user_bridge #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_IN_PORTS  = 4,
  parameter int NUM_OUT_PORTS = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                    clk,
  input  logic                                    ap_rst_n,
  input  logic                                    ap_start,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    din_if2bridge,
  input  logic [NUM_IN_PORTS-1:0]                 vld_if2bridge,
  output logic [NUM_IN_PORTS-1:0]                 ack_bridge2if,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    in_tdata,
  output logic [NUM_IN_PORTS-1:0]                 in_tvalid,
  input  logic [NUM_IN_PORTS-1:0]                 in_tready,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   out_tdata,
  input  logic [NUM_OUT_PORTS-1:0]                out_tvalid,
  output logic [NUM_OUT_PORTS-1:0]                out_tready,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   dout_bridge2if,
  output logic [NUM_OUT_PORTS-1:0]                vld_bridge2if,
  input  logic [NUM_OUT_PORTS-1:0]                ack_if2bridge,
  output logic                                    ap_start_user,
  input  logic                                    ap_done_user,
  output logic                                    done,
  output logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*32-1:0] word_cnt
);
  localparam int W  = PAYLOAD_BITS;
  localparam int NI = NUM_IN_PORTS;
  localparam int NC = NUM_IN_PORTS + NUM_OUT_PORTS;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  // Channels 0..NI-1 carry interface->kernel traffic, NI..NC-1 kernel->interface.
  logic [NC*W-1:0] wdata, rdata;
  logic [NC-1:0] wvalid, wready, rvalid, rready, push, pop;
  logic [NUM_OUT_PORTS-1:0] out_last;
  logic drained;
  assign wdata  = {out_tdata, din_if2bridge};
  assign wvalid = {out_tvalid, vld_if2bridge};
  assign rready = {ack_if2bridge, in_tready};
  assign {out_tready, ack_bridge2if} = wready;
  assign {vld_bridge2if, in_tvalid}  = rvalid;
  assign {dout_bridge2if, in_tdata}  = rdata;
  genvar c;
  generate
    for (c = 0; c < NC; c++) begin : g_ch
      logic [W-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0] wp, rp;
      logic [AW:0] cnt;
      assign wready[c] = cnt != (AW+1)'(FIFO_DEPTH);
      assign rvalid[c] = cnt != '0;
      assign rdata[c*W +: W] = mem[rp];
      assign push[c] = wvalid[c] && wready[c];
      assign pop[c]  = rvalid[c] && rready[c];
      // pointers and occupancy; reset flushes the FIFO
      always_ff @(posedge clk) begin
        if (!ap_rst_n) begin
          wp  <= '0;
          rp  <= '0;
          cnt <= '0;
        end else begin
          if (push[c]) wp <= wp + 1'b1;
          if (pop[c]) rp <= rp + 1'b1;
          cnt <= cnt + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
        end
      end
      // storage is not reset, so the head word just holds a stale value
      always_ff @(posedge clk) if (push[c]) mem[wp] <= wdata[c*W +: W];
      if (c >= NI) begin : g_last
        // empty now, or its only word leaves this cycle
        assign out_last[c-NI] = cnt == '0 || (cnt == (AW+1)'(1) && rready[c]);
      end
    end
  endgenerate
  // kernel is finished once every output FIFO empties with nothing more arriving
  assign drained = &out_last && !(|out_tvalid);
  assign ap_start_user = state == RUN;
  // state register
  always_ff @(posedge clk) state <= !ap_rst_n ? IDLE : state_nx;
  // next state; done marks the DRAIN->IDLE cycle
  always_comb begin
    state_nx = state;
    done = state == DRAIN && drained;
    if (state == IDLE && ap_start) state_nx = RUN;
    if (state == RUN && ap_done_user) state_nx = DRAIN;
    if (done) state_nx = IDLE;
  end
`ifdef LEAF_BRIDGE_CNT_EN
  logic [NC-1:0] xfer;
  logic start_run;
  assign xfer = {push[NC-1:NI], pop[NI-1:0]};
  assign start_run = state == IDLE && ap_start;
  generate
    for (c = 0; c < NC; c++) begin : g_cnt
      logic [31:0] n;
      // kernel-side transfer count, saturating, cleared when the kernel starts
      always_ff @(posedge clk) begin
        if (!ap_rst_n || start_run) n <= '0;
        else if (xfer[c] && n != '1) n <= n + 1'b1;
      end
      assign word_cnt[c*32 +: 32] = n;
    end
  endgenerate
`else
  assign word_cnt = '0;
`endif
endmodule

// File: tb/tb_leaf_user_bridge.sv
// tb_leaf_user_bridge: vector table, directed sequences and queue-model random check of leaf_user_bridge
module tb_leaf_user_bridge;
  localparam int W = 32, NI = 4, NO = 1, D = 4, NC = 5;
  logic clk = 1'b0;
  logic ap_rst_n, ap_start, ap_done_user, ap_start_user, done;
  logic [NI*W-1:0] din_if2bridge, in_tdata;
  logic [NI-1:0] vld_if2bridge, ack_bridge2if, in_tvalid, in_tready;
  logic [NO*W-1:0] out_tdata, dout_bridge2if;
  logic [NO-1:0] out_tvalid, out_tready, vld_bridge2if, ack_if2bridge;
  logic [NC*32-1:0] word_cnt;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  leaf_user_bridge #(.PAYLOAD_BITS(W), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .FIFO_DEPTH(D)) dut (
    .clk(clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .din_if2bridge(din_if2bridge), .vld_if2bridge(vld_if2bridge), .ack_bridge2if(ack_bridge2if),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .dout_bridge2if(dout_bridge2if), .vld_bridge2if(vld_bridge2if), .ack_if2bridge(ack_if2bridge),
    .ap_start_user(ap_start_user), .ap_done_user(ap_done_user), .done(done), .word_cnt(word_cnt)
  );
  // per-channel views: channel c < NI is an input channel, others are output channels
  logic [NC-1:0] t_wv, t_rr, t_rdy, t_vld;
  logic [NC*W-1:0] t_wd, t_rd;
  assign t_wv  = {out_tvalid, vld_if2bridge};
  assign t_rr  = {ack_if2bridge, in_tready};
  assign t_wd  = {out_tdata, din_if2bridge};
  assign t_rdy = {out_tready, ack_bridge2if};
  assign t_vld = {vld_bridge2if, in_tvalid};
  assign t_rd  = {dout_bridge2if, in_tdata};

  typedef struct packed {
    logic vld; logic [31:0] d; logic rdy;
    logic ack; logic tv; logic [31:0] td;
  } vec_t;
  vec_t tbl [10];
  logic [W-1:0] q [NC][$];
  int unsigned mc [NC];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  task automatic quiet;
    ap_start = 0; ap_done_user = 0;
    din_if2bridge = '0; vld_if2bridge = '0; in_tready = '0;
    out_tdata = '0; out_tvalid = '0; ack_if2bridge = '0;
  endtask
  task automatic do_reset;
    quiet();
    ap_rst_n = 0;
    cyc(); cyc();
    ap_rst_n = 1;
  endtask

  initial begin
    int dn;
    quiet();
    // reset with interface valids high: nothing may be pushed
    ap_rst_n = 0;
    vld_if2bridge = 4'hF;
    cyc(); cyc();
    chk("rst_ack", ack_bridge2if, 4'hF);
    chk("rst_out_tready", out_tready, 1'b1);
    chk("rst_in_tvalid", in_tvalid, 4'h0);
    chk("rst_vld_b2if", vld_bridge2if, 1'b0);
    chk("rst_ap_start_user", ap_start_user, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_word_cnt", word_cnt, '0);
    ap_rst_n = 1;
    vld_if2bridge = '0;
    settle(); cyc();
    chk("rst_no_push", in_tvalid, 4'h0);

    // prestart buffering on ch0
    for (int i = 0; i < 4; i++) begin
      din_if2bridge[0 +: W] = 32'h11 * (i + 1);
      vld_if2bridge[0] = 1;
      settle();
      chk("pre_ack", ack_bridge2if[0], 1'b1);
      chk("pre_tvalid", in_tvalid[0], i > 0);
      cyc();
    end
    din_if2bridge[0 +: W] = 32'h55;
    settle();
    chk("pre_full_ack", ack_bridge2if[0], 1'b0);
    vld_if2bridge[0] = 0;
    ap_start = 1;
    settle(); cyc();
    ap_start = 0;
    chk("pre_run", ap_start_user, 1'b1);
    in_tready[0] = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("pre_pop_valid", in_tvalid[0], 1'b1);
      chk("pre_pop_data", in_tdata[0 +: W], 32'h11 * (i + 1));
      cyc();
    end
    in_tready[0] = 0;
    settle();
    chk("pre_empty", in_tvalid[0], 1'b0);

    // done sequencing with 3 words held in the output FIFO
    for (int i = 0; i < 3; i++) begin
      out_tvalid = 1;
      out_tdata = 32'hD0 + i;
      settle(); cyc();
    end
    out_tvalid = 0;
    ap_done_user = 1;
    settle(); cyc();
    ap_done_user = 0;
    settle();
    chk("drain_start_user", ap_start_user, 1'b0);
    chk("drain_done_hold", done, 1'b0);
    chk("drain_vld", vld_bridge2if, 1'b1);
    cyc();
    chk("drain_done_hold2", done, 1'b0);
    ack_if2bridge = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("drain_data", dout_bridge2if, 32'hD0 + i);
      chk("drain_done", done, i == 2);
      cyc();
    end
    chk("drain_idle_done", done, 1'b0);
    chk("drain_idle_user", ap_start_user, 1'b0);
    ack_if2bridge = 0;

    // ap_start during RUN is ignored; exactly one done
    ap_start = 1;
    settle(); cyc();
    chk("col_run", ap_start_user, 1'b1);
    settle(); cyc();
    ap_start = 0;
    chk("col_start_ignored", ap_start_user, 1'b1);
    ap_done_user = 1;
    settle(); cyc();
    ap_done_user = 0;
    settle();
    chk("col_done_empty", done, 1'b1);
    cyc();
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      dn += int'(done);
      cyc();
    end
    chk("col_single_done", dn, 0);
    chk("col_idle", ap_start_user, 1'b0);
    // ap_start together with ap_done_user in RUN
    ap_start = 1;
    settle(); cyc();
    ap_done_user = 1;
    settle(); cyc();
    ap_start = 0; ap_done_user = 0;
    settle();
    chk("col_both_drain", ap_start_user, 1'b0);
    chk("col_both_done", done, 1'b1);
    cyc();
    chk("col_both_idle", ap_start_user, 1'b0);

    // reset while in DRAIN with 2 output words queued
    ap_start = 1;
    settle(); cyc();
    ap_start = 0;
    for (int i = 0; i < 2; i++) begin
      out_tvalid = 1;
      out_tdata = 32'hE0 + i;
      settle(); cyc();
    end
    out_tvalid = 0;
    ap_done_user = 1;
    settle(); cyc();
    ap_done_user = 0;
    settle();
    chk("rd_queued", vld_bridge2if, 1'b1);
    chk("rd_no_done", done, 1'b0);
    ap_rst_n = 0;
    settle(); cyc();
    ap_rst_n = 1;
    ack_if2bridge = 1;
    settle();
    chk("rd_flushed", vld_bridge2if, 1'b0);
    chk("rd_tready", out_tready, 1'b1);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      dn += int'(done);
      cyc();
    end
    chk("rd_idle_no_done", dn, 0);
    ack_if2bridge = 0;

`ifdef LEAF_BRIDGE_CNT_EN
    // transfer counters
    ap_start = 1;
    settle(); cyc();
    ap_start = 0;
    in_tready[1] = 1;
    for (int i = 0; i < 5; i++) begin
      vld_if2bridge[1] = 1;
      din_if2bridge[W +: W] = i;
      settle(); cyc();
    end
    vld_if2bridge[1] = 0;
    ack_if2bridge = 1;
    for (int i = 0; i < 7; i++) begin
      out_tvalid = 1;
      out_tdata = i;
      settle(); cyc();
    end
    out_tvalid = 0;
    cyc(); cyc();
    chk("cnt_in1", word_cnt[32 +: 32], 5);
    chk("cnt_out0", word_cnt[128 +: 32], 7);
    chk("cnt_in0", word_cnt[0 +: 32], 0);
    ap_done_user = 1;
    settle(); cyc();
    ap_done_user = 0;
    cyc();
    ap_start = 1;
    settle(); cyc();
    ap_start = 0;
    chk("cnt_clr_in1", word_cnt[32 +: 32], 0);
    chk("cnt_clr_out0", word_cnt[128 +: 32], 0);
    quiet();
`else
    in_tready[1] = 1;
    vld_if2bridge[1] = 1;
    settle(); cyc(); cyc();
    chk("cnt_tied_zero", word_cnt, '0);
    quiet();
`endif

    // vector table on ch3: fill, wrap, full-with-pop, drain
    tbl[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA0};
    tbl[2] = '{1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 32'hA0};
    tbl[3] = '{1'b1, 32'hA3, 1'b0, 1'b1, 1'b1, 32'hA1};
    tbl[4] = '{1'b1, 32'hA4, 1'b0, 1'b1, 1'b1, 32'hA1};
    tbl[5] = '{1'b1, 32'hA5, 1'b1, 1'b0, 1'b1, 32'hA1};
    tbl[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA2};
    tbl[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA3};
    tbl[8] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA4};
    tbl[9] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      vld_if2bridge[3] = tbl[i].vld;
      din_if2bridge[3*W +: W] = tbl[i].d;
      in_tready[3] = tbl[i].rdy;
      settle();
      chk("tbl_ack", ack_bridge2if[3], tbl[i].ack);
      chk("tbl_tvalid", in_tvalid[3], tbl[i].tv);
      if (tbl[i].tv) chk("tbl_tdata", in_tdata[3*W +: W], tbl[i].td);
      cyc();
    end

    // random traffic on all channels against per-channel queues
    do_reset();
    for (int c = 0; c < NC; c++) begin
      q[c].delete();
      mc[c] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      logic [NC-1:0] pu, po;
      vld_if2bridge = 4'($urandom);
      din_if2bridge = {$urandom, $urandom, $urandom, $urandom};
      in_tready = 4'($urandom);
      out_tvalid = 1'($urandom);
      out_tdata = $urandom;
      ack_if2bridge = 1'($urandom);
      settle();
      for (int c = 0; c < NC; c++) begin
        logic er, ev;
        er = q[c].size() < D;
        ev = q[c].size() > 0;
        chk("rnd_ready", t_rdy[c], er);
        chk("rnd_valid", t_vld[c], ev);
        if (ev) chk("rnd_data", t_rd[c*W +: W], q[c][0]);
        pu[c] = t_wv[c] && er;
        po[c] = t_rr[c] && ev;
      end
      cyc();
      for (int c = 0; c < NC; c++) begin
        if (po[c]) void'(q[c].pop_front());
        if (pu[c]) q[c].push_back(t_wd[c*W +: W]);
        if (c < NI ? po[c] : pu[c]) mc[c]++;
      end
    end
`ifdef LEAF_BRIDGE_CNT_EN
    for (int c = 0; c < NC; c++) chk("rnd_cnt", word_cnt[c*32 +: 32], mc[c]);
`else
    chk("rnd_cnt_zero", word_cnt, '0);
`endif
    chk("rnd_no_done", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
